fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register.
- Owns the PC and runs a req/ack handshake to instruction memory.
- Drives `addr`, `inst` and `delayslot_flag_in` of the decode stage.
- Consumes decode's `branch_flag`, `branch_addr` and `next_inst_delayslot_flag`, the pipeline `stall`, and the exception `flush`/`exc_pc`.

---
 rtl/fetch_stage.sv | 217 +++++++++++++++++++++
 tb/tb_fetch_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, PC ownership and req/ack memory handshake.
// Optional FETCH_ADDR_EXC_EN: misaligned PC raises id_addr_err instead of issuing a fetch.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] exc_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_addr,
    input  logic        next_inst_delayslot_flag,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ack,
    input  logic [31:0] inst_rdata,
    output logic [31:0] id_addr,
    output logic [31:0] id_inst,
    output logic        id_delayslot_flag,
    output logic        id_addr_err
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        KILL  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] kill_addr_reg, kill_addr_next;
    logic [31:0] br_target_reg, br_target_next;
    logic [31:0] buf_addr_reg, buf_addr_next;
    logic [31:0] buf_inst_reg, buf_inst_next;
    logic        br_pend_reg, br_pend_next;
    logic        ds_pend_reg, ds_pend_next;
    logic        id_valid_reg, id_valid_next;
    logic [31:0] id_addr_reg, id_addr_next;
    logic [31:0] id_inst_reg, id_inst_next;
    logic        id_ds_reg, id_ds_next;
    logic        id_err_reg, id_err_next;

    logic        misaligned;
    logic [31:0] req_addr;
    logic        ack_ok;
    logic        ds_now;
    logic [31:0] seq_pc;

    // KILL keeps presenting the abandoned address so the handshake stays stable.
    assign req_addr = (state_reg == KILL) ? kill_addr_reg : pc_reg;

`ifdef FETCH_ADDR_EXC_EN
    assign misaligned = (state_reg == FETCH) && (pc_reg[1:0] != 2'b00);
    assign inst_addr  = req_addr;
`else
    assign misaligned = 1'b0;
    assign inst_addr  = {req_addr[31:2], 2'b00};
`endif

    assign inst_req = ((state_reg == FETCH) && !misaligned) || (state_reg == KILL);
    assign ack_ok   = inst_req && inst_ack;
    // Decode flags the delay slot while its branch sits in ID; that may coincide with delivery.
    assign ds_now   = ds_pend_reg || (id_valid_reg && next_inst_delayslot_flag);

    always_comb begin
        seq_pc = pc_reg + PC_STEP;
        if (br_pend_reg) begin
            seq_pc = br_target_reg;
        end else if (branch_flag && !stall) begin
            seq_pc = branch_addr;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        kill_addr_next = kill_addr_reg;
        br_target_next = br_target_reg;
        buf_addr_next  = buf_addr_reg;
        buf_inst_next  = buf_inst_reg;
        br_pend_next   = br_pend_reg;
        ds_pend_next   = ds_pend_reg;
        id_valid_next  = id_valid_reg;
        id_addr_next   = id_addr_reg;
        id_inst_next   = id_inst_reg;
        id_ds_next     = id_ds_reg;
        id_err_next    = id_err_reg;

        if (flush) begin
            pc_next       = exc_pc;
            br_pend_next  = 1'b0;
            ds_pend_next  = 1'b0;
            id_valid_next = 1'b0;
            id_addr_next  = 32'h0;
            id_inst_next  = 32'h0;
            id_ds_next    = 1'b0;
            id_err_next   = 1'b0;
            if (state_reg == FETCH && inst_req && !inst_ack) begin
                state_next     = KILL;
                kill_addr_next = req_addr;
            end else if (state_reg == KILL && !inst_ack) begin
                state_next = KILL;
            end else begin
                state_next = FETCH;
            end
        end else begin
            if (!stall) begin
                id_valid_next = 1'b0;
                id_addr_next  = 32'h0;
                id_inst_next  = 32'h0;
                id_ds_next    = 1'b0;
                id_err_next   = 1'b0;
                ds_pend_next  = ds_now;
            end
            // Delay slot still in flight: remember the target until its fetch completes.
            if (branch_flag && !stall && state_reg != HOLD && !(state_reg == FETCH && ack_ok)) begin
                br_pend_next   = 1'b1;
                br_target_next = branch_addr;
            end

            case (state_reg)
                BOOT: begin
                    state_next = FETCH;
                end
                FETCH: begin
                    if (misaligned) begin
                        if (!stall) begin
                            id_valid_next = 1'b1;
                            id_addr_next  = pc_reg;
                            id_inst_next  = 32'h0;
                            id_ds_next    = ds_now;
                            id_err_next   = 1'b1;
                            ds_pend_next  = 1'b0;
                        end
                    end else if (ack_ok) begin
                        pc_next      = seq_pc;
                        br_pend_next = 1'b0;
                        if (!stall) begin
                            id_valid_next = 1'b1;
                            id_addr_next  = pc_reg;
                            id_inst_next  = inst_rdata;
                            id_ds_next    = ds_now;
                            ds_pend_next  = 1'b0;
                        end else begin
                            buf_addr_next = pc_reg;
                            buf_inst_next = inst_rdata;
                            state_next    = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        id_valid_next = 1'b1;
                        id_addr_next  = buf_addr_reg;
                        id_inst_next  = buf_inst_reg;
                        id_ds_next    = ds_now;
                        ds_pend_next  = 1'b0;
                        state_next    = FETCH;
                        // Buffered word is the delay slot; nothing is outstanding, so redirect now.
                        if (branch_flag) begin
                            pc_next = branch_addr;
                        end
                    end
                end
                KILL: begin
                    if (ack_ok) begin
                        state_next = FETCH;
                    end
                end
                default: begin
                    state_next = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= BOOT;
            pc_reg        <= RESET_PC;
            kill_addr_reg <= 32'h0;
            br_target_reg <= 32'h0;
            buf_addr_reg  <= 32'h0;
            buf_inst_reg  <= 32'h0;
            br_pend_reg   <= 1'b0;
            ds_pend_reg   <= 1'b0;
            id_valid_reg  <= 1'b0;
            id_addr_reg   <= 32'h0;
            id_inst_reg   <= 32'h0;
            id_ds_reg     <= 1'b0;
            id_err_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            kill_addr_reg <= kill_addr_next;
            br_target_reg <= br_target_next;
            buf_addr_reg  <= buf_addr_next;
            buf_inst_reg  <= buf_inst_next;
            br_pend_reg   <= br_pend_next;
            ds_pend_reg   <= ds_pend_next;
            id_valid_reg  <= id_valid_next;
            id_addr_reg   <= id_addr_next;
            id_inst_reg   <= id_inst_next;
            id_ds_reg     <= id_ds_next;
            id_err_reg    <= id_err_next;
        end
    end

    assign id_addr           = id_addr_reg;
    assign id_inst           = id_inst_reg;
    assign id_delayslot_flag = id_ds_reg;
    assign id_addr_err       = id_err_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage: per-cycle vectors with a scoreboard for the IF/ID register.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] exc_pc;
    logic        branch_flag;
    logic [31:0] branch_addr;
    logic        next_inst_delayslot_flag;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;
    logic [31:0] id_addr;
    logic [31:0] id_inst;
    logic        id_delayslot_flag;
    logic        id_addr_err;

    fetch_stage dut (
        .clk                      (clk),
        .rst                      (rst),
        .stall                    (stall),
        .flush                    (flush),
        .exc_pc                   (exc_pc),
        .branch_flag              (branch_flag),
        .branch_addr              (branch_addr),
        .next_inst_delayslot_flag (next_inst_delayslot_flag),
        .inst_req                 (inst_req),
        .inst_addr                (inst_addr),
        .inst_ack                 (inst_ack),
        .inst_rdata               (inst_rdata),
        .id_addr                  (id_addr),
        .id_inst                  (id_inst),
        .id_delayslot_flag        (id_delayslot_flag),
        .id_addr_err              (id_addr_err)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] C_BUB  = 2'd0;
    localparam logic [1:0] C_WORD = 2'd1;
    localparam logic [1:0] C_SAME = 2'd2;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] exc;
        logic        br;
        logic [31:0] baddr;
        logic        nds;
        logic        ack;
        logic        exp_req;
        logic [31:0] req_a;
        logic [1:0]  chk;
        logic [31:0] id_a;
        logic [31:0] id_i;
        logic        id_ds;
        logic        id_err;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] i;
        logic        ds;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t last_exp;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic v(input logic st, input logic fl, input logic [31:0] ex,
                     input logic br, input logic [31:0] ba, input logic nd, input logic ak,
                     input logic rq, input logic [31:0] ra,
                     input logic [1:0] ck, input logic [31:0] ia, input logic [31:0] ii,
                     input logic ids, input logic ie);
        vec_t r;
        r.stall = st; r.flush = fl; r.exc = ex; r.br = br; r.baddr = ba; r.nds = nd;
        r.ack = ak; r.exp_req = rq; r.req_a = ra; r.chk = ck;
        r.id_a = ia; r.id_i = ii; r.id_ds = ids; r.id_err = ie;
        vecs.push_back(r);
    endtask

    // Zero-wait fetch of ra delivered to ID on the following edge.
    task automatic fw(input logic [31:0] ra, input logic ds);
        v(0, 0, 0, 0, 0, 0, 1, 1, ra, C_WORD, ra, word_at(ra), ds, 0);
    endtask

    task automatic check_id(input string tag, input exp_t e);
        check32({tag, ".id_addr"}, id_addr, e.a);
        check32({tag, ".id_inst"}, id_inst, e.i);
        check32({tag, ".id_ds"}, {31'b0, id_delayslot_flag}, {31'b0, e.ds});
        check32({tag, ".id_err"}, {31'b0, id_addr_err}, {31'b0, e.err});
    endtask

    initial begin
        vec_t r;
        exp_t e;
        exp_t zero_e;
        zero_e = '{a: 32'h0, i: 32'h0, ds: 1'b0, err: 1'b0};

        // boot, sequential zero-wait fetch
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, C_BUB, 0, 0, 0, 0);
        fw(32'hBFC0_0000, 0);
        fw(32'hBFC0_0004, 0);
        fw(32'hBFC0_0008, 0);
        // ack under stall, held 3 cycles
        v(1, 0, 0, 0, 0, 0, 1, 1, 32'hBFC0_000C, C_SAME, 0, 0, 0, 0);
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, C_SAME, 0, 0, 0, 0);
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, C_SAME, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, C_WORD, 32'hBFC0_000C, word_at(32'hBFC0_000C), 0, 0);
        fw(32'hBFC0_0010, 0);
        // flush coinciding with ack, then branch with slow delay-slot fetch
        v(0, 1, 32'h100, 0, 0, 0, 1, 1, 32'hBFC0_0014, C_BUB, 0, 0, 0, 0);
        fw(32'h100, 0);
        v(0, 0, 0, 1, 32'h200, 1, 0, 1, 32'h104, C_BUB, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0, 1, 32'h104, C_BUB, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 1, 1, 32'h104, C_WORD, 32'h104, word_at(32'h104), 1, 0);
        fw(32'h200, 0);
        // flush with request outstanding at 0x40
        v(0, 1, 32'h40, 0, 0, 0, 1, 1, 32'h204, C_BUB, 0, 0, 0, 0);
        v(0, 1, 32'hBFC0_0380, 0, 0, 0, 0, 1, 32'h40, C_BUB, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0, 1, 32'h40, C_BUB, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 1, 1, 32'h40, C_BUB, 0, 0, 0, 0);
        fw(32'hBFC0_0380, 0);
        // pending branch, then flush + stall + branch together
        v(0, 0, 0, 1, 32'h500, 1, 0, 1, 32'hBFC0_0384, C_BUB, 0, 0, 0, 0);
        v(1, 1, 32'h600, 1, 32'h700, 1, 0, 1, 32'hBFC0_0384, C_BUB, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 1, 1, 32'hBFC0_0384, C_BUB, 0, 0, 0, 0);
        fw(32'h600, 0);
        fw(32'h604, 0);
        // 32-bit PC wrap
        v(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 1, 1, 32'h608, C_BUB, 0, 0, 0, 0);
        fw(32'hFFFF_FFFC, 0);
        fw(32'h0, 0);
        // misaligned redirect
        v(0, 1, 32'h102, 0, 0, 0, 1, 1, 32'h4, C_BUB, 0, 0, 0, 0);
`ifdef FETCH_ADDR_EXC_EN
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, C_WORD, 32'h102, 32'h0, 0, 1);
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, C_WORD, 32'h102, 32'h0, 0, 1);
`else
        v(0, 0, 0, 0, 0, 0, 1, 1, 32'h100, C_WORD, 32'h102, word_at(32'h100), 0, 0);
        v(0, 0, 0, 0, 0, 0, 1, 1, 32'h104, C_WORD, 32'h106, word_at(32'h104), 0, 0);
`endif

        rst = 1'b0; stall = 1'b0; flush = 1'b0; exc_pc = 32'h0;
        branch_flag = 1'b0; branch_addr = 32'h0; next_inst_delayslot_flag = 1'b0;
        inst_ack = 1'b0; inst_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check32("reset.inst_req", {31'b0, inst_req}, 32'h0);
        check_id("reset", zero_e);
        rst = 1'b1;
        last_exp = zero_e;

        for (int k = 0; k < vecs.size(); k++) begin
            r = vecs[k];
            stall = r.stall; flush = r.flush; exc_pc = r.exc;
            branch_flag = r.br; branch_addr = r.baddr; next_inst_delayslot_flag = r.nds;
            inst_ack = r.ack;
            inst_rdata = r.ack ? word_at(r.req_a) : 32'hDEAD_BEEF;
            #1;
            check32($sformatf("v%0d.inst_req", k), {31'b0, inst_req}, {31'b0, r.exp_req});
            if (r.exp_req) check32($sformatf("v%0d.inst_addr", k), inst_addr, r.req_a);
            case (r.chk)
                C_BUB:   e = zero_e;
                C_WORD:  e = '{a: r.id_a, i: r.id_i, ds: r.id_ds, err: r.id_err};
                default: e = last_exp;
            endcase
            last_exp = e;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL v%0d.scoreboard: got empty queue, expected one entry", k);
            end else begin
                e = sb.pop_front();
                check_id($sformatf("v%0d", k), e);
                $display("vec %0d: req=%0b addr=%h -> id_addr=%h id_inst=%h ds=%0b err=%0b",
                         k, r.exp_req, r.req_a, id_addr, id_inst, id_delayslot_flag, id_addr_err);
            end
        end

        // reset while a request may be outstanding, then restart and first-fetch latency
        stall = 1'b0; flush = 1'b0; branch_flag = 1'b0; next_inst_delayslot_flag = 1'b0;
        inst_ack = 1'b0; rst = 1'b0;
        @(posedge clk);
        #1;
        check32("midreset.inst_req", {31'b0, inst_req}, 32'h0);
        check_id("midreset", zero_e);
        rst = 1'b1;
        #1;
        check32("boot.inst_req", {31'b0, inst_req}, 32'h0);
        @(posedge clk);
        #1;
        check32("restart.inst_req", {31'b0, inst_req}, 32'h1);
        check32("restart.inst_addr", inst_addr, 32'hBFC0_0000);
        inst_ack = 1'b1;
        inst_rdata = word_at(32'hBFC0_0000);
        @(posedge clk);
        #1;
        check_id("restart", '{a: 32'hBFC0_0000, i: word_at(32'hBFC0_0000), ds: 1'b0, err: 1'b0});
        check32("restart.next_addr", inst_addr, 32'hBFC0_0004);
        $display("restart: id_addr=%h id_inst=%h next inst_addr=%h", id_addr, id_inst, inst_addr);
        inst_ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
